// File: rtl/dynamic_input_route_buffer.sv
// Input buffer for one router port: a credit-managed flit FIFO whose head flit
// requests an output port by XY dimension-order routing, held for a whole packet.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef CHIP_ID_WIDTH
`define CHIP_ID_WIDTH 14
`endif
`ifndef XY_WIDTH
`define XY_WIDTH 8
`endif
`ifndef PAYLOAD_LEN
`define PAYLOAD_LEN 8
`endif

module dynamic_input_route_buffer #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [`DATA_WIDTH-1:0] data_in,
    input  logic                   valid_in,
    output logic                   yummy_out,
    input  logic [`XY_WIDTH-1:0]   my_loc_x_in,
    input  logic [`XY_WIDTH-1:0]   my_loc_y_in,
    output logic [`DATA_WIDTH-1:0] data_out,
    output logic                   valid_out,
    output logic [4:0]             route_req_out,
    output logic                   tail_out,
    input  logic [4:0]             thanks_in,
    output logic                   overflow_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PL    = `PAYLOAD_LEN;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic {ST_HEAD, ST_BODY} state_t;

    logic [`DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]    count_q, count_d;
    state_t                 state_q, state_d;
    logic [PL-1:0]          remain_q, remain_d;
    logic [4:0]             route_q, route_d;
    logic                   yummy_q, yummy_d;
    logic                   overflow_q, overflow_d;

    logic [`XY_WIDTH-1:0] dest_x, dest_y;
    logic [PL-1:0]        pay_len;
    logic [4:0]           route_head, route_req;
    logic                 push, pop, full, empty;

    assign data_out = mem_q[rd_ptr_q];
    assign dest_x   = data_out[`DATA_WIDTH-`CHIP_ID_WIDTH-1 -: `XY_WIDTH];
    assign dest_y   = data_out[`DATA_WIDTH-`CHIP_ID_WIDTH-`XY_WIDTH-1 -: `XY_WIDTH];
    assign pay_len  = data_out[`DATA_WIDTH-`CHIP_ID_WIDTH-2*`XY_WIDTH-4 -: `PAYLOAD_LEN];

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

    // X is resolved before Y so routes stay deadlock-free on a mesh.
    always_comb begin
        route_head = 5'b10000;
        if (dest_x > my_loc_x_in)      route_head = 5'b00001;
        else if (dest_x < my_loc_x_in) route_head = 5'b00010;
        else if (dest_y > my_loc_y_in) route_head = 5'b00100;
        else if (dest_y < my_loc_y_in) route_head = 5'b01000;
    end

    assign route_req = (state_q == ST_BODY) ? route_q : (empty ? 5'b00000 : route_head);
    assign pop       = !empty && ((thanks_in & route_req) != 5'b00000);
    assign push      = valid_in && !full;

    assign valid_out     = !empty;
    assign route_req_out = route_req;
    assign tail_out      = !empty && (((state_q == ST_HEAD) && (pay_len == '0)) ||
                                      ((state_q == ST_BODY) && (remain_q == PL'(1))));
    assign yummy_out     = yummy_q;
    assign overflow_err  = overflow_q;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        state_d    = state_q;
        remain_d   = remain_q;
        route_d    = route_q;
        yummy_d    = pop;
        overflow_d = overflow_q | (valid_in & full);

        if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_HEAD: begin
                if (pop && (pay_len != '0)) begin
                    state_d  = ST_BODY;
                    remain_d = pay_len;
                    route_d  = route_head;
                end
            end
            ST_BODY: begin
                if (pop) begin
                    remain_d = remain_q - PL'(1);
                    if (remain_q == PL'(1)) state_d = ST_HEAD;
                end
            end
            default: state_d = ST_HEAD;
        endcase
    end

    // Flit storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= ST_HEAD;
            remain_q   <= '0;
            route_q    <= '0;
            yummy_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            remain_q   <= remain_d;
            route_q    <= route_d;
            yummy_q    <= yummy_d;
            overflow_q <= overflow_d;
        end
    end

endmodule
